riscv_trace_compressor: RTL

Consumes the per-cycle RISC-V retirement trace bus (the same `trace__*` bundle the trace checker samples) and compresses it into a stream of discontinuity packets: sync anchors, direct taken branches, indirect jumps/returns and traps, each carrying an instruction count. It sits directly downstream of the core's trace port, in parallel with the checker. It feeds a trace sink (debug buffer or DMA) through a 4-entry packet FIFO with a valid/ready handshake.

---
 rtl/riscv_trace_compressor_if.sv | 31 +++
 rtl/riscv_trace_compressor.sv | 121 ++++++++++++
 2 files changed

// File: rtl/riscv_trace_compressor_if.sv
// Trace-in / packet-out bundle for the trace compressor.
// The core side drives trace__*, and the sink drives pkt_ready.
interface riscv_trace_compressor_if;
  logic        trace__instr_valid;
  logic [31:0] trace__instr_pc;
  logic [2:0]  trace__mode;
  logic        trace__branch_taken;
  logic [31:0] trace__branch_target;
  logic        trace__trap;
  logic        trace__ret;
  logic        trace__jalr;

  logic        pkt_valid;
  logic        pkt_ready;
  logic [1:0]  pkt_type;
  logic [7:0]  pkt_count;
  logic [2:0]  pkt_mode;
  logic [31:0] pkt_addr;

  modport slave (
    input  trace__instr_valid, trace__instr_pc, trace__mode, trace__branch_taken,
           trace__branch_target, trace__trap, trace__ret, trace__jalr, pkt_ready,
    output pkt_valid, pkt_type, pkt_count, pkt_mode, pkt_addr
  );

  modport master (
    output trace__instr_valid, trace__instr_pc, trace__mode, trace__branch_taken,
           trace__branch_target, trace__trap, trace__ret, trace__jalr, pkt_ready,
    input  pkt_valid, pkt_type, pkt_count, pkt_mode, pkt_addr
  );
endinterface

// File: rtl/riscv_trace_compressor.sv
// Compresses the retirement trace into discontinuity packets (SYNC/BRANCH/INDIRECT/TRAP)
// and queues them in a 4-entry FIFO toward the trace sink.
module riscv_trace_compressor (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  riscv_trace_compressor_if.slave         trc,
  output logic                            overflow
);
  localparam logic [1:0] PKT_SYNC     = 2'd0;
  localparam logic [1:0] PKT_BRANCH   = 2'd1;
  localparam logic [1:0] PKT_INDIRECT = 2'd2;
  localparam logic [1:0] PKT_TRAP     = 2'd3;

  typedef struct packed {
    logic [1:0]  ptype;
    logic [7:0]  cnt;
    logic [2:0]  mode;
    logic [31:0] addr;
  } pkt_t;

  pkt_t       r_mem [4];
  logic [1:0] r_wr_ptr, r_rd_ptr;
  logic [2:0] r_occ;
  logic [7:0] r_count;
  logic       r_resync;
  logic       r_overflow;

  logic       w_consider, w_gen, w_valid, w_full, w_pop, w_push, w_drop, w_resync_nxt;
  logic [7:0] w_count_nxt, w_cnt_inc;
  pkt_t       w_pkt, w_head;

  assign w_consider = enable & trc.trace__instr_valid;
  assign w_cnt_inc  = r_count + 8'd1;

  // A pending resync swallows whatever the instruction does; its transfer becomes implicit.
  always_comb begin
    w_gen        = 1'b0;
    w_pkt        = '0;
    w_pkt.mode   = trc.trace__mode;
    w_count_nxt  = r_count;
    w_resync_nxt = r_resync;
    if (w_consider) begin
      if (r_resync) begin
        w_gen        = 1'b1;
        w_pkt.ptype  = PKT_SYNC;
        w_pkt.cnt    = r_count;
        w_pkt.addr   = trc.trace__instr_pc;
        w_count_nxt  = 8'd0;
        w_resync_nxt = 1'b0;
      end else if (trc.trace__trap) begin
        w_gen        = 1'b1;
        w_pkt.ptype  = PKT_TRAP;
        w_pkt.cnt    = w_cnt_inc;
        w_pkt.addr   = trc.trace__instr_pc;
        w_count_nxt  = 8'd0;
        w_resync_nxt = 1'b1;
      end else if (trc.trace__branch_taken) begin
        w_gen        = 1'b1;
        w_pkt.ptype  = (trc.trace__jalr | trc.trace__ret) ? PKT_INDIRECT : PKT_BRANCH;
        w_pkt.cnt    = w_cnt_inc;
        w_pkt.addr   = trc.trace__branch_target;
        w_count_nxt  = 8'd0;
      end else if (r_count == 8'hFF) begin
        w_gen        = 1'b1;
        w_pkt.ptype  = PKT_SYNC;
        w_pkt.cnt    = 8'hFF;
        w_pkt.addr   = trc.trace__instr_pc;
        w_count_nxt  = 8'd0;
      end else begin
        w_count_nxt  = w_cnt_inc;
      end
    end
  end

  assign w_valid = (r_occ != 3'd0);
  assign w_full  = (r_occ == 3'd4);
  assign w_pop   = w_valid & trc.pkt_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = w_gen & (~w_full | w_pop);
  assign w_drop  = w_gen & ~w_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_occ      <= 3'd0;
      r_count    <= 8'd0;
      r_resync   <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_occ <= r_occ + {2'b00, w_push} - {2'b00, w_pop};
      if (!enable) begin
        r_count  <= 8'd0;
        r_resync <= 1'b1;
      end else if (w_drop) begin
        r_count    <= 8'd0;
        r_resync   <= 1'b1;
        r_overflow <= 1'b1;
      end else begin
        r_count  <= w_count_nxt;
        r_resync <= w_resync_nxt;
      end
    end
  end

  // Storage needs no reset: it is only observed through the occupancy-gated outputs.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= w_pkt;
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign trc.pkt_valid = w_valid;
  assign trc.pkt_type  = w_valid ? w_head.ptype : 2'd0;
  assign trc.pkt_count = w_valid ? w_head.cnt   : 8'd0;
  assign trc.pkt_mode  = w_valid ? w_head.mode  : 3'd0;
  assign trc.pkt_addr  = w_valid ? w_head.addr  : 32'd0;
  assign overflow      = r_overflow;
endmodule
